tc_psum_sched: RTL and testbench
================================

Name: tc_psum_sched

Overview:
Scheduler and arbiter in front of the tensor-core partial-sum buffer (M x N accumulator). It accepts TILE_M-wide partial-sum beats from NUM_REQ PE-group requesters and grants them round-robin, one beat per cycle. It drives the buffer's row, col, data, input_en and out_en. Once every requester has flagged its last beat for the output block, it triggers a buffer drain and counts the drained rows.

Parameters:
NUM_REQ, 4, number of requesters (power of 2, >=2)
M, 16, buffer rows
N, 16, buffer columns
TILE_M, 4, rows carried per beat
DW_DATA, 8, bits per element
DW_POS, 4, row/col index width (2^DW_POS >= max(M,N))
DRAIN_ROWS, 16, psum_out_valid beats expected per drain (equals M)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begins an output block
req_valid  in  NUM_REQ  per-requester beat valid
req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
req_row  in  NUM_REQ*DW_POS  base row of beat, slice r
req_col  in  NUM_REQ*DW_POS  column of beat, slice r
req_data  in  NUM_REQ*TILE_M*DW_DATA  TILE_M partial sums, slice r
req_last  in  NUM_REQ  qualifies req_valid: final beat of this requester for the block
psum_row  out  DW_POS  buffer row
psum_col  out  DW_POS  buffer col
psum_in  out  TILE_M*DW_DATA  buffer data
psum_input_en  out  1  buffer input enable
psum_out_en  out  1  buffer output enable
psum_out_valid  in  1  buffer out_valid
busy  out  1  high in any state except IDLE
block_done  out  1  one-cycle pulse when the drain completes
err  out  1  sticky range error (see Optional Feature)

Behaviour:
- States: IDLE, ACCUM, FLUSH, DRAIN. Reset: state IDLE. All outputs are 0, including psum_in. Round-robin pointer = 0. last_mask = 0. Drain count = 0.
- IDLE:
  - start -> ACCUM.
  - psum_input_en pulses for exactly one cycle, registered, in the cycle after start.
  - last_mask is cleared.
- ACCUM:
  - Round-robin among the valid requesters. Priority starts at pointer; after a grant, pointer = granted index + 1 (mod NUM_REQ).
  - req_ready is combinational from req_valid and pointer. A requester whose last_mask bit is set is masked out.
  - Accepted beat = req_valid & req_ready. It is registered into psum_row/col/in one cycle later, so latency is 1.
  - The buffer accumulates every cycle it is in INPUT. On cycles with no accepted beat, psum_in must therefore be driven to 0; row and col hold their last value.
  - An accepted beat with req_last sets the requester's last_mask bit.
  - last_mask all ones, including a beat accepted this cycle -> FLUSH.
- FLUSH:
  - One cycle. psum_in = 0, which lets the final registered beat land.
  - psum_out_en is pulsed for one cycle.
  - -> DRAIN.
- DRAIN:
  - req_ready = 0.
  - Count psum_out_valid high cycles.
  - When the count reaches DRAIN_ROWS: block_done pulses, count resets, -> IDLE.
- start outside IDLE is ignored.
- rst mid-operation returns to the reset values on the next edge. Beats in flight are discarded.
- Arithmetic: no summation in this block; data passes through unmodified.

Optional Feature:
- Macro TC_PSUM_SCHED_CHECK_EN.
- When defined, each accepted beat is checked:
  - req_row is a multiple of TILE_M;
  - req_row + TILE_M <= M;
  - req_col < N.
- On a violation: err is set sticky until rst, and the beat is replaced by zero data so the buffer is not corrupted.
- When undefined: err is tied 0 and no checking logic is present.

Decomposition:
- Shared package tc_pkg holds:
  - the state encoding constants (IDLE/ACCUM/FLUSH/DRAIN);
  - default DW_DATA, DW_POS and TILE_M;
  - the log2 helper.
- Sub-module tc_rr_arb: a parameterised NUM_REQ round-robin arbiter with request mask, one-hot grant and pointer update. It is reused by the later weight-fetch scheduler.

Test Plan:
- Reset: rst high for 3 cycles with req_valid = 4'hF -> req_ready = 0, all psum_* = 0, busy = 0, block_done = 0.
- Fairness: start, then all 4 requesters valid continuously -> grant sequence 0,1,2,3,0,...; each beat's data appears on psum_in exactly 1 cycle after its grant.
- Idle zeroing: requester 2 sends row 4, col 7, data {1,2,3,4}, then all requests stop -> psum_in = 0 on every following cycle while in ACCUM.
- Completion: each requester sends 3 beats, the third with req_last -> masked requesters receive no further grants. Exactly one psum_out_en pulse occurs, 2 cycles after the final accepted beat. After 16 psum_out_valid cycles, block_done pulses once and busy falls.
- Reset mid-DRAIN: rst after 5 valid drain cycles -> IDLE; a new start gives a full 16-count drain.
- Range check, macro defined: beat with req_row = 14 -> err = 1 and psum_in = 0 for that beat. Macro undefined: err stays 0.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared tensor-core definitions: scheduler state encoding, default datapath widths
// and a ceiling-log2 helper used for index and counter sizing.
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int TC_DW_DATA = 8;
    localparam int TC_DW_POS  = 4;
    localparam int TC_TILE_M  = 4;

    // Minimum result of 1 so the value can always be used as a vector width.
    function automatic int log2_ceil(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/tc_rr_arb.sv
// Round-robin arbiter: one-hot grant among unmasked requests, priority starting at
// the pointer, pointer moves to one past the winner. NUM_REQ must be a power of 2.
module tc_rr_arb
    import tc_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = log2_ceil(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    logic [IW-1:0]      ptr;
    logic [NUM_REQ-1:0] eligible;
    logic [IW-1:0]      cand;
    logic               found;

    assign eligible = req & ~mask;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr + IW'(k);
            if (en && !found && eligible[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/tc_psum_sched.sv
// Partial-sum buffer scheduler: arbitrates requester beats into the buffer, then
// flushes and counts the drain. Optional range checking under TC_PSUM_SCHED_CHECK_EN.
module tc_psum_sched
    import tc_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int M          = 16,
    parameter int N          = 16,
    parameter int TILE_M     = TC_TILE_M,
    parameter int DW_DATA    = TC_DW_DATA,
    parameter int DW_POS     = TC_DW_POS,
    parameter int DRAIN_ROWS = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*DW_POS-1:0]         req_row,
    input  logic [NUM_REQ*DW_POS-1:0]         req_col,
    input  logic [NUM_REQ*TILE_M*DW_DATA-1:0] req_data,
    input  logic [NUM_REQ-1:0]                req_last,
    output logic [DW_POS-1:0]                 psum_row,
    output logic [DW_POS-1:0]                 psum_col,
    output logic [TILE_M*DW_DATA-1:0]         psum_in,
    output logic                              psum_input_en,
    output logic                              psum_out_en,
    input  logic                              psum_out_valid,
    output logic                              busy,
    output logic                              block_done,
    output logic                              err
);

    localparam int IW = log2_ceil(NUM_REQ);
    localparam int CW = log2_ceil(DRAIN_ROWS + 1);
    localparam int BW = TILE_M * DW_DATA;

    state_t              state, state_nxt;
    logic [NUM_REQ-1:0]  last_mask, mask_upd, grant;
    logic [IW-1:0]       grant_idx;
    logic [CW-1:0]       drain_cnt;
    logic                accept, drain_done;
    logic [DW_POS-1:0]   sel_row, sel_col;
    logic [BW-1:0]       sel_data, beat_data;

    tc_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (state == ST_ACCUM),
        .req       (req_valid),
        .mask      (last_mask),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign sel_row   = req_row[int'(grant_idx)*DW_POS +: DW_POS];
    assign sel_col   = req_col[int'(grant_idx)*DW_POS +: DW_POS];
    assign sel_data  = req_data[int'(grant_idx)*BW +: BW];
    assign mask_upd  = last_mask | ((accept && req_last[grant_idx]) ? grant : '0);
    assign drain_done = (state == ST_DRAIN) && psum_out_valid
                        && (drain_cnt == CW'(DRAIN_ROWS - 1));
    assign busy      = (state != ST_IDLE);

`ifdef TC_PSUM_SCHED_CHECK_EN
    logic beat_bad;
    logic err_q;

    always_comb begin
        beat_bad = accept && (((int'(sel_row) % TILE_M) != 0)
                              || (int'(sel_row) + TILE_M > M)
                              || (int'(sel_col) >= N));
    end

    // An out-of-range beat still lands, but as zeros so the accumulator is untouched.
    assign beat_data = beat_bad ? '0 : sel_data;

    always_ff @(posedge clk) begin
        if (rst)           err_q <= 1'b0;
        else if (beat_bad) err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign beat_data = sel_data;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start)         state_nxt = ST_ACCUM;
            ST_ACCUM: if (&mask_upd)     state_nxt = ST_FLUSH;
            ST_FLUSH:                    state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_done)    state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psum_row      <= '0;
            psum_col      <= '0;
            psum_in       <= '0;
            psum_input_en <= 1'b0;
            psum_out_en   <= 1'b0;
            block_done    <= 1'b0;
            last_mask     <= '0;
            drain_cnt     <= '0;
        end else begin
            psum_input_en <= (state == ST_IDLE) && start;
            psum_out_en   <= (state == ST_FLUSH);
            block_done    <= drain_done;

            if (state == ST_IDLE)       last_mask <= '0;
            else if (state == ST_ACCUM) last_mask <= mask_upd;

            // The buffer adds psum_in every cycle, so idle cycles must present zero.
            psum_in <= accept ? beat_data : '0;
            if (accept) begin
                psum_row <= sel_row;
                psum_col <= sel_col;
            end

            if (drain_done)                                 drain_cnt <= '0;
            else if ((state == ST_DRAIN) && psum_out_valid) drain_cnt <= drain_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_tc_psum_sched.sv
// Scoreboard bench for tc_psum_sched: directed stimulus pushes expected beats,
// a negedge monitor pops and compares whenever psum_in carries data.
module tb_tc_psum_sched;

    localparam int NR = 4;
    localparam int DP = 4;
    localparam int TM = 4;
    localparam int DD = 8;
    localparam int BW = TM * DD;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*DP-1:0]  req_row = '0;
    logic [NR*DP-1:0]  req_col = '0;
    logic [NR*BW-1:0]  req_data = '0;
    logic [NR-1:0]     req_last = '0;
    logic [DP-1:0]     psum_row, psum_col;
    logic [BW-1:0]     psum_in;
    logic              psum_input_en, psum_out_en, busy, block_done, err;
    logic              psum_out_valid = 1'b0;

    tc_psum_sched #(
        .NUM_REQ(NR), .M(16), .N(16), .TILE_M(TM), .DW_DATA(DD), .DW_POS(DP), .DRAIN_ROWS(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .req_valid(req_valid), .req_ready(req_ready), .req_row(req_row), .req_col(req_col),
        .req_data(req_data), .req_last(req_last),
        .psum_row(psum_row), .psum_col(psum_col), .psum_in(psum_in),
        .psum_input_en(psum_input_en), .psum_out_en(psum_out_en), .psum_out_valid(psum_out_valid),
        .busy(busy), .block_done(block_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [DP-1:0] row;
        logic [DP-1:0] col;
        logic [BW-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int oe_cnt = 0;
    int bd_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (psum_out_en) oe_cnt++;
            if (block_done)  bd_cnt++;
            if (psum_in != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(psum_in), 64'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_latency", 64'(cyc), 64'(e.cyc));
                    check("beat_row", 64'(psum_row), 64'(e.row));
                    check("beat_col", 64'(psum_col), 64'(e.col));
                    check("beat_data", 64'(psum_in), 64'(e.data));
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] beat_data(input int r, input int n);
        int b;
        b = r * 16 + n * 4;
        return {8'(b + 1), 8'(b + 2), 8'(b + 3), 8'(b + 4)};
    endfunction

    task automatic drive_req(input int r, input int row, input int col,
                             input logic [BW-1:0] data, input logic last);
        req_row[r*DP +: DP]  = DP'(row);
        req_col[r*DP +: DP]  = DP'(col);
        req_data[r*BW +: BW] = data;
        req_last[r]          = last;
    endtask

    // Expected beat appears on the buffer port the cycle after it is granted.
    task automatic push(input int row, input int col, input logic [BW-1:0] data);
        beat_t e;
        e.cyc  = cyc + 1;
        e.row  = DP'(row);
        e.col  = DP'(col);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic one_beat_block(input int p0);
        int g;
        next_cycle();
        start = 1'b1;
        req_valid = '0;
        #2;
        check("blk_idle_busy", 64'(busy), 64'd0);
        for (int i = 0; i < NR; i++) begin
            next_cycle();
            start = 1'b0;
            req_valid = '1;
            for (int r = 0; r < NR; r++) drive_req(r, r * 4, 8 + r, beat_data(r, 12), 1'b1);
            #2;
            if (i == 0) check("blk_input_en", 64'(psum_input_en), 64'd1);
            g = (p0 + i) % NR;
            check("blk_grant", 64'(req_ready), 64'(1 << g));
            push(g * 4, 8 + g, beat_data(g, 12));
        end
        next_cycle();
        #2;
        check("blk_flush_out_en", 64'(psum_out_en), 64'd0);
        check("blk_flush_ready", 64'(req_ready), 64'd0);
        next_cycle();
        #2;
        check("blk_out_en", 64'(psum_out_en), 64'd1);
    endtask

    task automatic run_drain();
        int  cnt;
        logic pend, v, fin;
        cnt  = 0;
        pend = 1'b0;
        fin  = 1'b0;
        for (int k = 0; k < 40 && !fin; k++) begin
            next_cycle();
            v = (cnt < 16) && (k % 3 != 2);
            psum_out_valid = v;
            #2;
            check("drain_block_done", 64'(block_done), 64'(pend));
            check("drain_busy", 64'(busy), 64'(!pend));
            check("drain_ready", 64'(req_ready), 64'd0);
            if (pend) fin = 1'b1;
            if (v) cnt++;
            pend = v && (cnt == 16);
        end
        check("drain_finished", 64'(fin), 64'd1);
        next_cycle();
        #2;
        check("drain_done_one_cycle", 64'(block_done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent[NR];
        int ord[12];
        int g;
        int oe_base, bd_base;

        // Reset with every requester asking
        req_valid = '1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #3;
            check("rst_ready", 64'(req_ready), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_psum_in", 64'(psum_in), 64'd0);
        end
        check("rst_row", 64'(psum_row), 64'd0);
        check("rst_col", 64'(psum_col), 64'd0);
        check("rst_flags", 64'({psum_input_en, psum_out_en, block_done, err}), 64'd0);
        next_cycle();
        rst = 1'b0;
        req_valid = '0;

        // Fairness: all requesters valid, pointer starts at 0
        next_cycle();
        start = 1'b1;
        #2;
        check("start_busy_pre", 64'(busy), 64'd0);
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            start = 1'b0;
            req_valid = '1;
            for (int r = 0; r < NR; r++) drive_req(r, r * 4, i, beat_data(r, i), 1'b0);
            #2;
            if (i == 0) check("input_en_pulse", 64'(psum_input_en), 64'd1);
            if (i == 1) check("input_en_single", 64'(psum_input_en), 64'd0);
            check("fair_grant", 64'(req_ready), 64'(1 << (i % NR)));
            push((i % NR) * 4, i, beat_data(i % NR, i));
        end

        // Idle zeroing after a lone beat from requester 2
        next_cycle();
        req_valid = 4'b0100;
        drive_req(2, 4, 7, 32'h01020304, 1'b0);
        #2;
        check("lone_grant", 64'(req_ready), 64'b0100);
        push(4, 7, 32'h01020304);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            req_valid = '0;
            #2;
            check("idle_ready", 64'(req_ready), 64'd0);
            if (k >= 1) begin
                check("idle_psum_zero", 64'(psum_in), 64'd0);
                check("idle_row_hold", 64'({psum_row, psum_col}), 64'({4'd4, 4'd7}));
                check("idle_busy", 64'(busy), 64'd1);
            end
        end

        // Completion: three beats each, pointer now at 3
        ord = '{3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
        sent = '{0, 0, 0, 0};
        oe_base = oe_cnt;
        bd_base = bd_cnt;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            req_valid = '1;
            for (int r = 0; r < NR; r++)
                drive_req(r, r * 4, sent[r], beat_data(r, sent[r]), sent[r] >= 2);
            #2;
            g = ord[i];
            check("cmp_grant", 64'(req_ready), 64'(1 << g));
            push(g * 4, sent[g], beat_data(g, sent[g]));
            sent[g]++;
        end
        next_cycle();
        #2;
        check("cmp_masked_ready", 64'(req_ready), 64'd0);
        check("cmp_out_en_early", 64'(psum_out_en), 64'd0);
        next_cycle();
        #2;
        check("cmp_out_en", 64'(psum_out_en), 64'd1);
        check("cmp_flush_zero", 64'(psum_in), 64'd0);
        run_drain();
        check("cmp_out_en_pulses", 64'(oe_cnt - oe_base), 64'd1);
        check("cmp_done_pulses", 64'(bd_cnt - bd_base), 64'd1);

        // Reset in the middle of a drain, then a full drain
        one_beat_block(3);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            psum_out_valid = 1'b1;
            #2;
            check("middrain_done", 64'(block_done), 64'd0);
        end
        next_cycle();
        psum_out_valid = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #2;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        check("mid_rst_outs", 64'({psum_row, psum_col, psum_in}), 64'd0);
        bd_base = bd_cnt;
        one_beat_block(0);
        run_drain();
        check("rst_drain_done_pulses", 64'(bd_cnt - bd_base), 64'd1);

        // Out-of-range row
        next_cycle();
        start = 1'b1;
        req_valid = '0;
        next_cycle();
        start = 1'b0;
        req_valid = 4'b0001;
        drive_req(0, 14, 0, 32'hAABBCCDD, 1'b0);
        #2;
        check("range_grant", 64'(req_ready), 64'b0001);
`ifndef TC_PSUM_SCHED_CHECK_EN
        push(14, 0, 32'hAABBCCDD);
`endif
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            req_valid = '0;
            #2;
`ifdef TC_PSUM_SCHED_CHECK_EN
            check("range_err", 64'(err), 64'd1);
            check("range_zero", 64'(psum_in), 64'd0);
`else
            check("range_err_off", 64'(err), 64'd0);
`endif
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
